// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse keyer: FSM state encoding, symbol
// values and element durations in Morse units, plus two small helpers that
// pick the next valid symbol out of a 5-bit valid mask.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MARK     = 2'd1,
        GAP      = 2'd2,
        CHAR_GAP = 2'd3
    } state_t;

    localparam logic SYM_PONTO = 1'b0;
    localparam logic SYM_TRACO = 1'b1;

    localparam logic [1:0] DOT_UNITS      = 2'd1;
    localparam logic [1:0] DASH_UNITS     = 2'd3;
    localparam logic [1:0] GAP_UNITS      = 2'd1;
    localparam logic [1:0] CHAR_GAP_UNITS = 2'd3;

    // Highest set mask bit strictly below index 'below' (pass 5 for "any").
    function automatic logic [2:0] next_valid(input logic [4:0] mask,
                                              input logic [2:0] below);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (mask[i] && (i < int'(below))) idx = 3'(i);
        end
        return idx;
    endfunction

    // True when some mask bit below index 'below' is still to be sent.
    function automatic logic has_below(input logic [4:0] mask,
                                       input logic [2:0] below);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mask[i] && (i < int'(below))) found = 1'b1;
        end
        return found;
    endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// -----------------------------------------------------------------------------
// morse_keyer_if
// Character handshake and keyed outputs between a sequencer (master) and the
// keyer (slave).
//   ready      : start strobe, sampled only while the keyer is idle
//   morse      : symbol pattern, 1 = dash, 0 = dot
//   display    : valid mask for the morse bits
//   key        : high while a mark sounds
//   ponto_out  : high during a dot mark
//   traco_out  : high during a dash mark
//   busy       : high while a character is being played
//   done       : one-cycle pulse on the last cycle of the character gap
// -----------------------------------------------------------------------------
interface morse_keyer_if;
    logic       ready;
    logic [4:0] morse;
    logic [4:0] display;
    logic       key;
    logic       ponto_out;
    logic       traco_out;
    logic       busy;
    logic       done;

    modport master (
        output ready, morse, display,
        input  key, ponto_out, traco_out, busy, done
    );

    modport slave (
        input  ready, morse, display,
        output key, ponto_out, traco_out, busy, done
    );
endinterface

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Prescaler producing one unit tick every UNIT_CYCLES clocks after a clear.
//   i_clk       : clock
//   i_reset     : synchronous active-high reset
//   i_clear     : restart the unit from its first cycle
//   o_unit_tick : high on the last cycle of each unit
// -----------------------------------------------------------------------------
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_unit_tick
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] TC = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] r_presc;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_presc <= '0;
        end else if (r_presc == TC) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign o_unit_tick = (r_presc == TC);

endmodule

// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
// Plays one latched Morse character (pattern + valid mask) as a keyed on/off
// signal, MSB symbol first, with standard unit timing.
//   i_clk   : clock
//   i_reset : synchronous active-high reset, overrides everything
//   bus     : morse_keyer_if.slave (ready/morse/display in; key, ponto_out,
//             traco_out, busy, done out)
//
// state    | meaning
// IDLE     | waiting for ready; latches the character on acceptance
// MARK     | key on for 1 (dot) or 3 (dash) units
// GAP      | key off for 1 unit between symbols
// CHAR_GAP | key off for 3 units; done on its last cycle
// -----------------------------------------------------------------------------
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    morse_keyer_if.slave  bus
);

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_morse;
    logic [4:0] r_mask;
    logic [2:0] r_idx;
    logic [1:0] r_units;

    logic       w_tick;
    logic       w_clear;
    logic       w_load;
    logic       w_sym;
    logic       w_more;
    logic [1:0] w_target;
    logic       w_unit_done;

    assign w_sym  = r_morse[r_idx];
    assign w_more = has_below(r_mask, r_idx);

    always_comb begin
        w_target = GAP_UNITS;
        case (r_state)
            MARK:     w_target = (w_sym == SYM_TRACO) ? DASH_UNITS : DOT_UNITS;
            GAP:      w_target = GAP_UNITS;
            CHAR_GAP: w_target = CHAR_GAP_UNITS;
            default:  w_target = GAP_UNITS;
        endcase
    end

    assign w_unit_done = w_tick && (r_units == (w_target - 2'd1));

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ready) begin
                    w_load       = 1'b1;
                    w_state_next = (|bus.display) ? MARK : CHAR_GAP;
                end
            end
            MARK: begin
                if (w_unit_done) w_state_next = w_more ? GAP : CHAR_GAP;
            end
            GAP: begin
                if (w_unit_done) w_state_next = MARK;
            end
            CHAR_GAP: begin
                if (w_unit_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Every element starts from a fresh unit; idle keeps the timer parked.
    assign w_clear = (w_state_next != r_state) || (r_state == IDLE);

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_clear),
        .o_unit_tick (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_morse <= '0;
            r_mask  <= '0;
            r_idx   <= '0;
            r_units <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_morse <= bus.morse;
                r_mask  <= bus.display;
                r_idx   <= next_valid(bus.display, 3'd5);
            end else if ((r_state == GAP) && w_unit_done) begin
                r_idx <= next_valid(r_mask, r_idx);
            end
            if (w_clear) begin
                r_units <= '0;
            end else if (w_tick) begin
                r_units <= r_units + 2'd1;
            end
        end
    end

    assign bus.key       = (r_state == MARK);
    assign bus.ponto_out = (r_state == MARK) && (w_sym == SYM_PONTO);
    assign bus.traco_out = (r_state == MARK) && (w_sym == SYM_TRACO);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == CHAR_GAP) && w_unit_done;

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
// Two keyers (2 and 1 cycles per unit). Each character's expected per-cycle
// output vector {key, ponto_out, traco_out, busy, done} is built from Morse
// timing rules and compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_morse_keyer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    morse_keyer_if if2 ();
    morse_keyer_if if1 ();

    morse_keyer #(.UNIT_CYCLES(2)) dut2 (.i_clk(clk), .i_reset(reset), .bus(if2));
    morse_keyer #(.UNIT_CYCLES(1)) dut1 (.i_clk(clk), .i_reset(reset), .bus(if1));

    int n_pass  = 0;
    int n_total = 0;

    logic [4:0] exp_q[$];

    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_DOT  = 5'b11010;
    localparam logic [4:0] V_DASH = 5'b10110;
    localparam logic [4:0] V_OFF  = 5'b00010;
    localparam logic [4:0] V_DONE = 5'b00011;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    function automatic logic [4:0] sample(input int sel);
        if (sel == 1) return {if1.key, if1.ponto_out, if1.traco_out, if1.busy, if1.done};
        return {if2.key, if2.ponto_out, if2.traco_out, if2.busy, if2.done};
    endfunction

    // Waveform of one character from the cycle after acceptance to done.
    function automatic void build(input logic [4:0] m, input logic [4:0] d, input int u);
        bit first;
        first = 1'b1;
        exp_q.delete();
        for (int b = 4; b >= 0; b--) begin
            if (d[b]) begin
                if (!first) for (int k = 0; k < u; k++) exp_q.push_back(V_OFF);
                first = 1'b0;
                if (m[b]) for (int k = 0; k < 3 * u; k++) exp_q.push_back(V_DASH);
                else      for (int k = 0; k < u; k++)     exp_q.push_back(V_DOT);
            end
        end
        for (int k = 0; k < 3 * u - 1; k++) exp_q.push_back(V_OFF);
        exp_q.push_back(V_DONE);
    endfunction

    task automatic drive(input int sel, input logic r, input logic [4:0] m, input logic [4:0] d);
        if (sel == 1) begin
            if1.ready = r; if1.morse = m; if1.display = d;
        end else begin
            if2.ready = r; if2.morse = m; if2.display = d;
        end
    endtask

    // Caller is one #1 after a rising edge with the keyer idle. With hold set,
    // ready stays high and the next play must follow immediately.
    task automatic play(input int sel, input logic [4:0] m, input logic [4:0] d,
                        input bit hold, input string tag);
        int u;
        u = (sel == 1) ? 1 : 2;
        build(m, d, u);
        drive(sel, 1'b1, m, d);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(sel, hold, 5'($urandom), 5'($urandom));
            check($sformatf("%s cyc%0d", tag, i), sample(sel), exp_q[i]);
        end
        @(posedge clk); #1;
        check($sformatf("%s idle", tag), sample(sel), V_IDLE);
    endtask

    initial begin
        logic [4:0] m;
        logic [4:0] d;
        bit         h;

        drive(2, 1'b0, 5'd0, 5'd0);
        drive(1, 1'b0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset u2", sample(2), V_IDLE);
        check("reset u1", sample(1), V_IDLE);
        reset = 1'b0;
        @(posedge clk); #1;

        play(2, 5'b00000, 5'b10000, 1'b0, "E");
        play(2, 5'b01000, 5'b11000, 1'b0, "A left");
        play(2, 5'b00001, 5'b00011, 1'b0, "A right");
        play(2, 5'b10101, 5'b00000, 1'b0, "empty");
        play(2, 5'b01000, 5'b11000, 1'b1, "hold A");
        play(2, 5'b10000, 5'b11000, 1'b0, "hold N");

        // Reset during the dash of 'A': dot(2) gap(2) then dash from cycle 4.
        drive(2, 1'b1, 5'b01000, 5'b11000);
        @(posedge clk); #1;
        drive(2, 1'b0, 5'b11111, 5'b11111);
        repeat (4) @(posedge clk);
        #1;
        check("pre-reset dash", sample(2), V_DASH);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset mid dash", sample(2), V_IDLE);
        reset = 1'b0;
        @(posedge clk); #1;
        check("after reset idle", sample(2), V_IDLE);
        play(2, 5'b00000, 5'b10000, 1'b0, "E after reset");

        play(1, 5'b11111, 5'b11111, 1'b0, "zero u1");
        play(1, 5'b00000, 5'b10000, 1'b0, "E u1");

        for (int n = 0; n < 24; n++) begin
            m = 5'($urandom);
            d = 5'($urandom);
            h = (n != 23) && ($urandom_range(0, 1) == 1);
            play(2, m, d, h, $sformatf("rand2 %0d", n));
        end
        for (int n = 0; n < 8; n++) begin
            m = 5'($urandom);
            d = 5'($urandom);
            h = (n != 7) && ($urandom_range(0, 1) == 1);
            play(1, m, d, h, $sformatf("rand1 %0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
